// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer sequencer and the network top.
// Holds the sequencer state encoding, default datapath sizing and the
// per-layer dilation factors used when the activation caches are built.
package conv_pkg;

  localparam int DEFAULT_W          = 16;
  localparam int DEFAULT_NUM_LAYERS = 3;

  // Dilation of the inputs to layers 1 and 2; sizes activation caches 0 and 1.
  localparam int DILATION_L1 = 4;
  localparam int DILATION_L2 = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_IN = 3'd1,
    START    = 3'd2,
    WAIT     = 3'd3,
    CACHE    = 3'd4,
    EMIT     = 3'd5
  } seq_state_t;

  function automatic int dilation(input int layer);
    return (layer == 1) ? DILATION_L1 : (layer == 2) ? DILATION_L2 : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer engine watchdog.
// Counts cycles while en is high. clear restarts the count.
// expired is high in the enabled cycle that is cycle TIMEOUT_CYCLES of the window.
// Ports: clk, rst (sync, active high), clear, en, expired.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Time-multiplexes one conv1d engine across NUM_LAYERS dilated causal layers.
// The sequencer runs one full network evaluation per accepted sample.
// Inputs:
//   - sample_v/inp: new sample.
//   - clr_flags: clears the sticky flags.
//   - eng_out_v/eng_out_d0..3: engine result.
// Outputs:
//   - sample_q: captured sample.
//   - lsb_shift: shift buffer strobe.
//   - layer_sel/relu_en: layer mux select and activation enable.
//   - eng_rst: engine start pulse.
//   - cache_shift: one-hot activation cache strobe.
//   - out_d0..3/out_v: final network output.
//   - busy, overrun, timeout: status.
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int NUM_LAYERS     = DEFAULT_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CW = (NUM_LAYERS > 1) ? NUM_LAYERS - 1 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_v,
  input  logic [W-1:0]  inp,
  input  logic          clr_flags,
  output logic [W-1:0]  sample_q,
  output logic          lsb_shift,
  output logic [LW-1:0] layer_sel,
  output logic          relu_en,
  output logic          eng_rst,
  input  logic          eng_out_v,
  input  logic [W-1:0]  eng_out_d0,
  input  logic [W-1:0]  eng_out_d1,
  input  logic [W-1:0]  eng_out_d2,
  input  logic [W-1:0]  eng_out_d3,
  output logic [CW-1:0] cache_shift,
  output logic [W-1:0]  out_d0,
  output logic [W-1:0]  out_d1,
  output logic [W-1:0]  out_d2,
  output logic [W-1:0]  out_d3,
  output logic          out_v,
  output logic          busy,
  output logic          overrun,
  output logic          timeout
);

  localparam logic [2:0] S_IDLE     = IDLE;
  localparam logic [2:0] S_SHIFT_IN = SHIFT_IN;
  localparam logic [2:0] S_START    = START;
  localparam logic [2:0] S_WAIT     = WAIT;
  localparam logic [2:0] S_CACHE    = CACHE;
  localparam logic [2:0] S_EMIT     = EMIT;

  localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);

  logic [2:0]    state, nxt;
  logic          wd_expired, abort, is_last;
  logic [LW-1:0] layer_nxt;

  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_START),
    .en      (state == S_WAIT),
    .expired (wd_expired)
  );

  assign is_last   = (layer_sel == LAST);
  // eng_out_v in the last allowed cycle takes priority over the watchdog.
  assign abort     = (state == S_WAIT) && !eng_out_v && wd_expired;
  assign layer_nxt = (state == S_CACHE) ? LW'(layer_sel + 1'b1) : layer_sel;
  assign busy      = (state != S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (sample_v) nxt = S_SHIFT_IN;
      S_SHIFT_IN: nxt = S_START;
      S_START:    nxt = S_WAIT;
      S_WAIT: begin
        if (eng_out_v)  nxt = is_last ? S_EMIT : S_CACHE;
        else if (abort) nxt = S_IDLE;
      end
      S_CACHE:    nxt = S_START;
      S_EMIT:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next-state value so each one is high
  // exactly while the FSM sits in its own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sample_q    <= '0;
      lsb_shift   <= 1'b0;
      layer_sel   <= '0;
      relu_en     <= 1'b1;
      eng_rst     <= 1'b0;
      cache_shift <= '0;
      out_d0      <= '0;
      out_d1      <= '0;
      out_d2      <= '0;
      out_d3      <= '0;
      out_v       <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= nxt;
      lsb_shift   <= (nxt == S_SHIFT_IN);
      eng_rst     <= (nxt == S_START);
      out_v       <= (nxt == S_EMIT);
      cache_shift <= (nxt == S_CACHE) ? (CW'(1) << layer_sel) : '0;

      if (state == S_IDLE && sample_v) begin
        sample_q  <= inp;
        layer_sel <= '0;
      end else begin
        layer_sel <= layer_nxt;
      end

      if (nxt == S_START) relu_en <= (layer_nxt != LAST);

      // Engine data is only valid alongside eng_out_v. Capture it on the way
      // into EMIT so that out_d lines up with out_v.
      if (state == S_WAIT && eng_out_v && is_last) begin
        out_d0 <= eng_out_d0;
        out_d1 <= eng_out_d1;
        out_d2 <= eng_out_d2;
        out_d3 <= eng_out_d3;
      end

      // A new event beats a coincident clear.
      overrun <= (sample_v && state != S_IDLE) || (overrun && !clr_flags);
      timeout <= abort || (timeout && !clr_flags);
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
module tb_conv_layer_sequencer;
  localparam int W  = 16;
  localparam int NL = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst, sample_v, clr_flags, eng_out_v;
  logic [W-1:0] inp, sample_q;
  logic [W-1:0] eng_out_d0, eng_out_d1, eng_out_d2, eng_out_d3;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
  logic lsb_shift, relu_en, eng_rst, out_v, busy, overrun, timeout;
  logic [1:0] layer_sel;
  logic [NL-2:0] cache_shift;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0, stub_lat = 4, k = 0, kn;
  int n_lsb = 0, n_cache = 0, n_outv = 0, n_push = 0;
  logic [3:0][W-1:0] stub_d, last_d;

  typedef struct { logic [3:0][W-1:0] d; int off; } exp_t;
  exp_t sb[$];
  exp_t mon_e, push_e;

  typedef struct { logic [W-1:0] x; int lat; logic [3:0][W-1:0] d; bit to; } vec_t;
  vec_t vt [6];

  conv_layer_sequencer #(.W(W), .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .sample_v(sample_v), .inp(inp), .clr_flags(clr_flags),
    .sample_q(sample_q), .lsb_shift(lsb_shift), .layer_sel(layer_sel),
    .relu_en(relu_en), .eng_rst(eng_rst), .eng_out_v(eng_out_v),
    .eng_out_d0(eng_out_d0), .eng_out_d1(eng_out_d1),
    .eng_out_d2(eng_out_d2), .eng_out_d3(eng_out_d3),
    .cache_shift(cache_shift), .out_d0(out_d0), .out_d1(out_d1),
    .out_d2(out_d2), .out_d3(out_d3), .out_v(out_v), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stub engine: eng_out_v is high exactly stub_lat cycles after an eng_rst cycle.
  // stub_lat = 0 means the engine never responds.
  always @(posedge clk) begin
    if (rst)                          kn = 0;
    else if (eng_rst && stub_lat > 0) kn = stub_lat;
    else if (k > 0)                   kn = k - 1;
    else                              kn = 0;
    k         <= kn;
    eng_out_v <= (kn == 1);
    cyc       <= cyc + 1;
  end

  assign eng_out_d0 = (layer_sel == 2'(NL - 1)) ? stub_d[0] : 16'hDEAD;
  assign eng_out_d1 = (layer_sel == 2'(NL - 1)) ? stub_d[1] : 16'hDEAD;
  assign eng_out_d2 = (layer_sel == 2'(NL - 1)) ? stub_d[2] : 16'hDEAD;
  assign eng_out_d3 = (layer_sel == 2'(NL - 1)) ? stub_d[3] : 16'hDEAD;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_off(input int lat);
    return 2 + (NL - 1) * (lat + 2) + lat + 1;
  endfunction

  // Scoreboard consumer: every out_v must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (lsb_shift) n_lsb++;
      if (|cache_shift) n_cache++;
      if (out_v) begin
        n_outv++;
        if (sb.size() == 0) chk("unexpected_out_v", 64'(1), 64'(0));
        else begin
          mon_e = sb.pop_front();
          chk("out_data", {out_d3, out_d2, out_d1, out_d0}, mon_e.d);
          chk("out_v_latency", 64'(cyc - t0), 64'(mon_e.off));
        end
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
    sample_v  = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] x, input bit ok);
    sample_v = 1'b1;
    inp      = x;
    t0       = cyc;
    if (ok) begin
      push_e.d   = stub_d;
      push_e.off = exp_off(stub_lat);
      sb.push_back(push_e);
      last_d = stub_d;
      n_push++;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      next();
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("wait_idle", 64'(done), 64'(1));
  endtask

  task automatic clr();
    next(); clr_flags = 1'b1;
    next();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 64'({sample_q, layer_sel, lsb_shift, eng_rst, cache_shift,
                             out_v, busy, overrun, timeout, relu_en}), 64'(1));
    chk({name, "_data"}, {out_d3, out_d2, out_d1, out_d0}, 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [5:0] tr_exp;
    int snap, lsb0;
    vt[0] = '{16'h0123, 4, {16'h8000, 16'h7FFF, 16'hFFEE, 16'h0011}, 1'b0};
    vt[1] = '{16'h0456, 1, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b0};
    vt[2] = '{16'h0789, 8, {16'hFFFF, 16'h1234, 16'h5555, 16'hAAAA}, 1'b0};
    vt[3] = '{16'h0ABC, 0, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b1};
    vt[4] = '{16'h0DEF, 9, {16'h5151, 16'h6262, 16'h7373, 16'h8484}, 1'b1};
    vt[5] = '{16'h0FED, 2, {16'hFF00, 16'h00FF, 16'hF0F0, 16'h0F0F}, 1'b0};

    rst = 1'b1; sample_v = 1'b0; inp = '0; clr_flags = 1'b0;
    stub_d = '0; last_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Nominal trace, L=4: cycle-exact strobe pattern.
    stub_lat = 4;
    stub_d = {16'h8000, 16'h7FFF, 16'hFFEE, 16'h0011};
    next(); drive(16'h0123, 1'b1);
    for (int off = 0; off <= 20; off++) begin
      @(negedge clk);
      tr_exp = {off == 1, off == 2 || off == 8 || off == 14,
                (off == 7) ? 2'b01 : (off == 13) ? 2'b10 : 2'b00,
                off == 19, off >= 1 && off <= 19};
      chk($sformatf("trace_off%0d", off),
          64'({lsb_shift, eng_rst, cache_shift, out_v, busy}), 64'(tr_exp));
      if (off == 2 || off == 8 || off == 14) begin
        chk($sformatf("layer_sel_off%0d", off), 64'(layer_sel), 64'((off - 2) / 6));
        chk($sformatf("relu_en_off%0d", off), 64'(relu_en), 64'(off != 14));
      end
      next();
    end
    chk("nominal_sample_q", 64'(sample_q), 64'(16'h0123));
    chk("nominal_lsb_count", 64'(n_lsb), 64'(1));

    // Table of runs: latency sweep, edge timeout, and aborts.
    foreach (vt[i]) begin
      clr();
      stub_lat = vt[i].lat;
      stub_d   = vt[i].d;
      drive(vt[i].x, !vt[i].to);
      wait_idle(80);
      chk($sformatf("vec%0d_timeout", i), 64'(timeout), 64'(vt[i].to));
      chk($sformatf("vec%0d_overrun", i), 64'(overrun), 64'(0));
      chk($sformatf("vec%0d_out_d", i), {out_d3, out_d2, out_d1, out_d0}, last_d);
      chk($sformatf("vec%0d_sample_q", i), 64'(sample_q), 64'(vt[i].x));
      if (vt[i].to) chk($sformatf("vec%0d_abort_cycle", i), 64'(cyc - t0), 64'(3 + TO));
    end

    // Overrun mid-run, plus overrun coinciding with clr_flags.
    stub_lat = 4;
    stub_d = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    next(); drive(16'h0123, 1'b1); lsb0 = n_lsb;
    repeat (5) next();
    sample_v = 1'b1; inp = 16'h5555;
    next(); sample_v = 1'b1; clr_flags = 1'b1;
    next(); @(negedge clk);
    chk("overrun_set_beats_clr", 64'(overrun), 64'(1));
    wait_idle(60);
    chk("overrun_sticky", 64'(overrun), 64'(1));
    chk("overrun_no_extra_lsb", 64'(n_lsb - lsb0), 64'(1));
    chk("overrun_sample_q", 64'(sample_q), 64'(16'h0123));
    clr(); @(negedge clk);
    chk("overrun_cleared", 64'({overrun, timeout}), 64'(0));

    // Sample arriving during EMIT is dropped.
    next(); drive(16'h0AAA, 1'b1);
    repeat (19) next();
    sample_v = 1'b1; inp = 16'h0BBB;
    next(); @(negedge clk);
    chk("emit_drop_busy", 64'(busy), 64'(0));
    chk("emit_drop_overrun", 64'(overrun), 64'(1));
    chk("emit_drop_sample_q", 64'(sample_q), 64'(16'h0AAA));
    clr();

    // Back-to-back: sample in the cycle after out_v is accepted.
    next(); drive(16'h0C01, 1'b1);
    repeat (20) next();
    stub_d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    drive(16'h0C02, 1'b1);
    wait_idle(60);
    chk("b2b_overrun", 64'(overrun), 64'(0));
    chk("b2b_sample_q", 64'(sample_q), 64'(16'h0C02));

    // Reset during layer-1 WAIT.
    next(); drive(16'h0CCC, 1'b0);
    repeat (10) next();
    rst = 1'b1; snap = n_cache;
    next(); rst = 1'b0;
    @(negedge clk);
    chk_zero("midrun_reset");
    last_d = '0;
    repeat (8) next();
    chk("midrun_no_cache_shift", 64'(n_cache), 64'(snap));
    stub_d = {16'h8000, 16'h7FFF, 16'hFFEE, 16'h0011};
    next(); drive(16'h0123, 1'b1);
    wait_idle(60);
    chk("post_reset_out_d", {out_d3, out_d2, out_d1, out_d0}, last_d);

    repeat (3) next();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    chk("out_v_count", 64'(n_outv), 64'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
